axil_reg_if_wr: RTL and testbench

AXI-Lite slave write channel to simple register-interface bridge; write-direction counterpart of the register read bridge.
Accepts AW and W independently and holds each in a single-entry register. Issues one reg_wr_en strobe per transaction, ended by reg_wr_ack or a timeout, then returns a B response.
Sits between the AXI-Lite interconnect and register files and CSR blocks.

---
 rtl/axil_reg_if_wr.sv | 70 +++++++
 tb/tb_axil_reg_if_wr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_if_wr.sv
// axil_reg_if_wr: AXI-Lite write channel to register-interface bridge.
// AW and W are held in single-entry registers until the register side acks or times out.
module axil_reg_if_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
  logic          aw_held, w_held;
  logic [CW-1:0] cnt;
  logic          aw_hs, w_hs, done, aw_nx, w_nx, b_nx, en_nx;
  logic          unused;
  assign unused         = ^s_axil_awprot;
  assign s_axil_awready = !aw_held;
  assign s_axil_wready  = !w_held;
  assign s_axil_bresp   = 2'b00;
  assign aw_hs = s_axil_awvalid && !aw_held;
  assign w_hs  = s_axil_wvalid && !w_held;
  assign done  = reg_wr_en && (reg_wr_ack || cnt == '0);
  assign aw_nx = (aw_held && !done) || aw_hs;
  assign w_nx  = (w_held && !done) || w_hs;
  // completion wins over a same-cycle B handshake, so the new B stays visible
  assign b_nx  = done || (s_axil_bvalid && !s_axil_bready);
  assign en_nx = aw_nx && w_nx && !b_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axil_bvalid <= 1'b0;
      reg_wr_en     <= 1'b0;
      cnt           <= CMAX;
      reg_wr_addr   <= '0;
      reg_wr_data   <= '0;
      reg_wr_strb   <= '0;
    end else begin
      aw_held       <= aw_nx;
      w_held        <= w_nx;
      s_axil_bvalid <= b_nx;
      reg_wr_en     <= en_nx;
      if (aw_hs) reg_wr_addr <= s_axil_awaddr;
      if (w_hs) begin
        reg_wr_data <= s_axil_wdata;
        reg_wr_strb <= s_axil_wstrb;
      end
      cnt <= !reg_wr_en ? CMAX : (!reg_wr_wait && cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
endmodule

// File: tb/tb_axil_reg_if_wr.sv
// tb_axil_reg_if_wr: directed and random writes checked against a transaction-level model
// and a queue scoreboard of captured address/data.
module tb_axil_reg_if_wr;
  localparam int TIMEOUT = 4;
  logic        clk = 0, rst_n = 0;
  logic [31:0] s_axil_awaddr = 0;
  logic [2:0]  s_axil_awprot = 0;
  logic        s_axil_awvalid = 0, s_axil_awready;
  logic [31:0] s_axil_wdata = 0;
  logic [3:0]  s_axil_wstrb = 0;
  logic        s_axil_wvalid = 0, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready = 1;
  logic [31:0] reg_wr_addr, reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_wr_wait = 0, reg_wr_ack = 0;
  int total = 0, bad = 0;
  logic [31:0] aw_q[$], wd_q[$];
  logic [3:0]  ws_q[$];
  bit m_aw, m_w, m_b, m_en, m_new;
  int m_nw;

  axil_reg_if_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a write is pending once both halves are accepted, runs
  // while no B is outstanding, and ends on ack or after TIMEOUT-1 non-waiting cycles.
  always @(negedge clk) begin
    logic [31:0] ea, ed;
    logic [3:0]  es;
    bit done, aw_n, w_n, b_n, en_n;
    if (!rst_n) begin
      chk("rst_en", reg_wr_en, 0);
      chk("rst_bvalid", s_axil_bvalid, 0);
      chk("rst_awready", s_axil_awready, 1);
      chk("rst_wready", s_axil_wready, 1);
      {m_aw, m_w, m_b, m_en, m_new} = 0;
      m_nw = 0;
    end else begin
      chk("awready", s_axil_awready, !m_aw);
      chk("wready", s_axil_wready, !m_w);
      chk("en", reg_wr_en, m_en);
      chk("bvalid", s_axil_bvalid, m_b);
      if (s_axil_bvalid) chk("bresp", s_axil_bresp, 0);
      if (m_new) begin
        if (aw_q.size() == 0 || wd_q.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
          ea = aw_q.pop_front(); ed = wd_q.pop_front(); es = ws_q.pop_front();
          chk("addr", reg_wr_addr, ea);
          chk("data", reg_wr_data, ed);
          chk("strb", reg_wr_strb, es);
        end
      end
      done = m_en && (reg_wr_ack || m_nw == TIMEOUT - 1);
      if (m_en && !reg_wr_wait && !done) m_nw++;
      b_n  = done || (m_b && !s_axil_bready);
      aw_n = (m_aw && !done) || s_axil_awvalid && !m_aw;
      w_n  = (m_w && !done) || s_axil_wvalid && !m_w;
      en_n = aw_n && w_n && !b_n;
      m_new = en_n && !m_en;
      if (m_new) m_nw = 0;
      {m_aw, m_w, m_b, m_en} = {aw_n, w_n, b_n, en_n};
    end
  end

  task automatic send_aw(input logic [31:0] a, input int gap);
    bit hs = 0;
    repeat (gap) @(posedge clk);
    #1 s_axil_awaddr = a; s_axil_awvalid = 1; s_axil_awprot = 3'($urandom);
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk); hs = s_axil_awready;
      if (hs) aw_q.push_back(a);
      @(posedge clk); #1;
    end
    s_axil_awvalid = 0;
    if (!hs) chk("aw_handshake_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int gap);
    bit hs = 0;
    repeat (gap) @(posedge clk);
    #1 s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk); hs = s_axil_wready;
      if (hs) begin wd_q.push_back(d); ws_q.push_back(s); end
      @(posedge clk); #1;
    end
    s_axil_wvalid = 0;
    if (!hs) chk("w_handshake_timeout", 0, 1);
  endtask

  task automatic wait_en(output bit ok);
    int t = 0;
    do begin @(negedge clk); t++; end while (!reg_wr_en && t < 100);
    ok = reg_wr_en;
    if (!ok) chk("en_wait_timeout", 0, 1);
  endtask

  task automatic count_en(input string name, input int exp);
    bit ok;
    int n = 0;
    wait_en(ok);
    if (ok) begin
      while (reg_wr_en && n < 100) begin n++; @(negedge clk); end
      chk(name, n, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 0;
    #1;
    chk("async_en", reg_wr_en, 0);
    chk("async_bvalid", s_axil_bvalid, 0);
    chk("async_awready", s_axil_awready, 1);
    chk("async_wready", s_axil_wready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    aw_q.delete(); wd_q.delete(); ws_q.delete();
  endtask

  initial begin
    bit ok, rdone;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    // same-cycle AW+W with immediate ack
    reg_wr_ack = 1; s_axil_bready = 1;
    fork send_aw(32'h10, 0); send_w(32'hDEADBEEF, 4'hF, 0); count_en("en_len_imm", 1); join
    repeat (3) @(posedge clk);
    // W ahead of AW
    fork send_aw(32'h24, 2); send_w(32'h1234_5678, 4'h3, 0); count_en("en_len_wfirst", 1); join
    repeat (3) @(posedge clk);
    // timeout with no wait
    #1 reg_wr_ack = 0;
    fork send_aw(32'h30, 0); send_w(32'hA5A5_A5A5, 4'hC, 1); count_en("en_len_timeout", TIMEOUT); join
    repeat (3) @(posedge clk);
    // wait holds off the timeout; ack ends it
    #1 reg_wr_wait = 1;
    fork
      send_aw(32'h40, 0); send_w(32'h0BAD_F00D, 4'h1, 0); count_en("en_len_wait", 11);
      begin wait_en(ok); repeat (10) @(posedge clk); #1 reg_wr_ack = 1; end
    join
    #1 reg_wr_wait = 0; reg_wr_ack = 1;
    repeat (2) @(posedge clk);
    // B held back while a second write waits
    #1 s_axil_bready = 0;
    send_aw(32'h50, 0); send_w(32'h1111_2222, 4'hF, 0);
    fork send_aw(32'h54, 0); send_w(32'h3333_4444, 4'h6, 0); join
    repeat (5) @(posedge clk);
    #1 s_axil_bready = 1;
    repeat (5) @(posedge clk);
    // reset while en is high, then while bvalid is high
    #1 reg_wr_ack = 0; reg_wr_wait = 1;
    fork send_aw(32'h60, 0); send_w(32'h6060_6060, 4'hF, 0); wait_en(ok); join
    do_reset();
    #1 reg_wr_ack = 1; reg_wr_wait = 0;
    repeat (5) @(posedge clk);
    #1 s_axil_bready = 0;
    fork send_aw(32'h70, 0); send_w(32'h7070_7070, 4'hF, 0); join
    repeat (3) @(posedge clk);
    do_reset();
    #1 s_axil_bready = 1;
    repeat (5) @(posedge clk);
    fork send_aw(32'h10, 0); send_w(32'hDEADBEEF, 4'hF, 0); count_en("en_len_after_rst", 1); join
    // random traffic
    rdone = 0;
    fork
      begin
        for (int k = 0; k < 60; k++)
          fork
            send_aw($urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));
            send_w($urandom, 4'($urandom), $urandom_range(0, 3));
          join
        rdone = 1;
      end
      while (!rdone) begin
        @(posedge clk);
        #1 reg_wr_ack = ($urandom_range(0, 3) == 0);
        reg_wr_wait = ($urandom_range(0, 2) == 0);
        s_axil_bready = ($urandom_range(0, 1) == 0);
      end
    join
    #1 reg_wr_ack = 1; reg_wr_wait = 0; s_axil_bready = 1;
    repeat (20) @(posedge clk);
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", wd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
